// File: rtl/dc_metric_pd.sv
// Delay-and-correlate timing metric |sum x[n-k]*x[n-k-DELAY]| with threshold/run-length plateau detector.
// Latency: metric_valid 4 cycles after in_valid, detect 1 cycle after the qualifying metric; no backpressure.
module dc_metric_pd #(
  parameter int DATA_W     = 16,
  parameter int DELAY      = 16,
  parameter int WIN        = 16,
  parameter int PROD_SHIFT = 16,
  parameter int ACC_W      = 24,
  parameter int MIN_RUN    = 8,
  parameter int HOLDOFF    = 64,
  parameter int IDX_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic [ACC_W-1:0]         thresh,
  output logic [ACC_W-1:0]         metric,
  output logic                     metric_valid,
  output logic                     detect,
  output logic [IDX_W-1:0]         peak_idx
);

  localparam int PRIME = DELAY + WIN - 1;
  localparam int PCW   = $clog2(PRIME + 1);
  localparam int MW    = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;
  localparam int RW    = $clog2(MIN_RUN + 1);
  localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {SEARCH, RUN, HOLD} state_t;

  logic signed [DATA_W-1:0] dly [DELAY];
  logic signed [DATA_W-1:0] s1_x, s1_xd;
  logic                     s1_vld, s1_live;
  logic [PCW-1:0]           prime_cnt;

  logic signed [MW-1:0]     prod_full;
  logic [ACC_W-1:0]         s2_p;
  logic                     s2_vld, s2_live;

  logic [ACC_W-1:0]         win [WIN];
  logic [ACC_W-1:0]         acc;
  logic                     s3_live;

  logic [IDX_W-1:0]         m_idx;

  state_t                   state, state_n;
  logic [RW-1:0]            run_cnt, run_n;
  logic [HW-1:0]            hold_cnt, hold_n;
  logic [ACC_W-1:0]         pk_val, pkv_n;
  logic [IDX_W-1:0]         pk_idx, pki_n;
  logic                     fire, hit;

  // S1: capture sample and its lagged partner; the live flag marks samples past priming
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) dly[i] <= '0;
      s1_x      <= '0;
      s1_xd     <= '0;
      s1_vld    <= 1'b0;
      s1_live   <= 1'b0;
      prime_cnt <= '0;
    end else begin
      s1_vld  <= in_valid;
      s1_live <= in_valid && (prime_cnt == PCW'(PRIME));
      if (in_valid) begin
        s1_x   <= in_data;
        s1_xd  <= dly[DELAY-1];
        dly[0] <= in_data;
        for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
        if (prime_cnt != PCW'(PRIME)) prime_cnt <= prime_cnt + PCW'(1);
      end
    end
  end

  always_comb begin
    prod_full = MW'(s1_x) * MW'(s1_xd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_p    <= '0;
      s2_vld  <= 1'b0;
      s2_live <= 1'b0;
    end else begin
      s2_vld  <= s1_vld;
      s2_live <= s1_live;
      if (s1_vld) s2_p <= ACC_W'(prod_full >>> PROD_SHIFT);
    end
  end

  // S3: running sum; the product leaving the window is subtracted as the new one enters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      acc     <= '0;
      s3_live <= 1'b0;
    end else begin
      s3_live <= s2_vld && s2_live;
      if (s2_vld) begin
        acc    <= acc + s2_p - win[WIN-1];
        win[0] <= s2_p;
        for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      metric       <= '0;
      metric_valid <= 1'b0;
      m_idx        <= '0;
    end else begin
      metric_valid <= s3_live;
      if (s3_live) metric <= acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;
      if (metric_valid) m_idx <= m_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    hold_n  = hold_cnt;
    pkv_n   = pk_val;
    pki_n   = pk_idx;
    fire    = 1'b0;
    hit     = (metric >= thresh);
    if (metric_valid) begin
      case (state)
        SEARCH: begin
          if (hit) begin
            run_n = RW'(1);
            pkv_n = metric;
            pki_n = m_idx;
            if (MIN_RUN == 1) begin
              fire    = 1'b1;
              state_n = HOLD;
              hold_n  = HW'(HOLDOFF);
            end else begin
              state_n = RUN;
            end
          end
        end
        RUN: begin
          if (hit) begin
            run_n = run_cnt + RW'(1);
            // strict compare so equal later values keep the earliest index
            if (metric > pk_val) begin
              pkv_n = metric;
              pki_n = m_idx;
            end
            if (run_n == RW'(MIN_RUN)) begin
              fire    = 1'b1;
              state_n = HOLD;
              hold_n  = HW'(HOLDOFF);
            end
          end else begin
            state_n = SEARCH;
          end
        end
        HOLD: begin
          if (hold_cnt <= HW'(1)) begin
            state_n = SEARCH;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt - HW'(1);
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      run_cnt  <= '0;
      hold_cnt <= '0;
      pk_val   <= '0;
      pk_idx   <= '0;
      detect   <= 1'b0;
      peak_idx <= '0;
    end else begin
      state    <= state_n;
      run_cnt  <= run_n;
      hold_cnt <= hold_n;
      pk_val   <= pkv_n;
      pk_idx   <= pki_n;
      detect   <= fire;
      if (fire) peak_idx <= pki_n;
    end
  end

endmodule

// File: tb/tb_dc_metric_pd.sv
// Directed bench for dc_metric_pd: metric values/latency, priming, gap handling, detector run/holdoff/reset.
module tb_dc_metric_pd;
  localparam int DATA_W = 16, DELAY = 4, WIN = 4, PROD_SHIFT = 16, ACC_W = 24;
  localparam int MIN_RUN = 3, HOLDOFF = 5, IDX_W = 16;
  localparam int PRIME = DELAY + WIN - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     in_valid = 1'b0;
  logic [ACC_W-1:0]         thresh = '1;
  logic [ACC_W-1:0]         metric;
  logic                     metric_valid;
  logic                     detect;
  logic [IDX_W-1:0]         peak_idx;

  dc_metric_pd #(
    .DATA_W(DATA_W), .DELAY(DELAY), .WIN(WIN), .PROD_SHIFT(PROD_SHIFT), .ACC_W(ACC_W),
    .MIN_RUN(MIN_RUN), .HOLDOFF(HOLDOFF), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .thresh(thresh),
    .metric(metric), .metric_valid(metric_valid), .detect(detect), .peak_idx(peak_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int in_cyc[$], mv_cyc[$], mv_val[$], det_cyc[$], det_idx[$];
  int exp_m[$], exp_di[$], exp_dm[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (in_valid && !rst) in_cyc.push_back(cyc);
    if (metric_valid) begin
      mv_val.push_back(int'(metric));
      mv_cyc.push_back(cyc);
    end
    if (detect) begin
      det_cyc.push_back(cyc);
      det_idx.push_back(int'(peak_idx));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one valid sample of value k*256, so products become k*k' after the >>>16
  task automatic feed(input int k);
    in_data  = 16'(k * 256);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic one_sample(input int k, input int th);
    thresh = 24'(th);
    feed(k);
    idle(6);
  endtask

  task automatic pulse_reset(input int n);
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    in_cyc.delete(); mv_cyc.delete(); mv_val.delete(); det_cyc.delete(); det_idx.delete();
    exp_m.delete(); exp_di.delete(); exp_dm.delete();
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, " metric"}, metric, 0);
    chk({tag, " metric_valid"}, metric_valid, 0);
    chk({tag, " detect"}, detect, 0);
    chk({tag, " peak_idx"}, peak_idx, 0);
  endtask

  task automatic fill(input int val, input int n);
    repeat (n) exp_m.push_back(val);
  endtask

  task automatic check_metrics(input string tag);
    chk({tag, " count"}, mv_val.size(), exp_m.size());
    for (int j = 0; j < exp_m.size() && j < mv_val.size(); j++) begin
      chk($sformatf("%s m%0d", tag, j), mv_val[j], exp_m[j]);
      if (j + PRIME < in_cyc.size())
        chk($sformatf("%s lat%0d", tag, j), mv_cyc[j] - in_cyc[j + PRIME], 4);
      else
        chk($sformatf("%s lat%0d", tag, j), -1, 4);
    end
  endtask

  task automatic check_detects(input string tag);
    chk({tag, " det count"}, det_cyc.size(), exp_di.size());
    for (int j = 0; j < exp_di.size() && j < det_cyc.size(); j++) begin
      chk($sformatf("%s det%0d idx", tag, j), det_idx[j], exp_di[j]);
      if (exp_dm[j] < mv_cyc.size())
        chk($sformatf("%s det%0d lat", tag, j), det_cyc[j] - mv_cyc[exp_dm[j]], 1);
      else
        chk($sformatf("%s det%0d lat", tag, j), -1, 1);
    end
  endtask

  int kv[12] = '{3, -2, 5, 1, 4, -3, 2, -6, 7, 1, -4, 9};

  initial begin
    // constant 0x4000: 7 priming samples, then steady 16384
    pulse_reset(2);
    check_zero("rst0");
    thresh = '1;
    repeat (12) feed(64);
    idle(8);
    fill(16384, 5);
    check_metrics("const");
    check_detects("const");

    // +/- alternating blocks of four drive the accumulator negative
    pulse_reset(1);
    for (int i = 0; i < 16; i++) feed(((i / 4) % 2 == 0) ? 64 : -64);
    idle(8);
    fill(16384, 9);
    check_metrics("alt");

    // mixed-sign samples, gapless then with random gaps: same hand-computed metrics
    pulse_reset(1);
    foreach (kv[i]) feed(kv[i]);
    idle(8);
    exp_m = '{22, 38, 29, 11, 37};
    check_metrics("mix");

    pulse_reset(1);
    foreach (kv[i]) begin
      repeat ($urandom_range(0, 3)) begin
        in_data  = 16'($urandom);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      feed(kv[i]);
    end
    idle(8);
    exp_m = '{22, 38, 29, 11, 37};
    check_metrics("gap");
    check_detects("gap");

    // detector: A=20 steady (1600), four B=30 samples raise the plateau to 2400
    pulse_reset(1);
    thresh = 24'd2100;
    repeat (12) feed(20);
    repeat (4) feed(30);
    repeat (12) feed(20);
    idle(8);
    thresh = 24'd1000;
    repeat (16) feed(20);
    idle(8);
    fill(1600, 5); fill(1800, 1); fill(2000, 1); fill(2200, 1); fill(2400, 5);
    fill(2200, 1); fill(2000, 1); fill(1800, 1); fill(1600, 21);
    check_metrics("det");
    exp_di = '{8, 21, 29};
    exp_dm = '{9, 23, 31};
    check_detects("det");

    // reset while run_cnt=2 and the third qualifying metric is on the output
    repeat (3) feed(20);
    idle(4);
    pulse_reset(1);
    check_zero("rst_run");

    // priming restarts; a below-threshold sample aborts the run, which restarts at index 3
    thresh = 24'd1000;
    repeat (7) feed(20);
    one_sample(20, 1000);
    one_sample(20, 1000);
    one_sample(20, 2000);
    one_sample(20, 1000);
    one_sample(20, 1000);
    one_sample(20, 1000);
    fill(1600, 6);
    check_metrics("restart");
    exp_di = '{3};
    exp_dm = '{5};
    check_detects("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dc_metric_pd.md
# dc_metric_pd

Parametrised delay-and-correlate timing metric with integrated plateau detector for the LiFi OFDM receiver synchroniser. Computes M[n] = |Σ_{k=0..WIN-1} x[n-k]·x[n-k-DELAY]| on a valid-qualified real sample stream, with separately configurable delay and window lengths. A threshold/run-length FSM raises a one-cycle `detect` pulse carrying the index of the metric peak. Sits between the ADC-side stream and the synchroniser's frame-start logic.

## Interface
- `DATA_W`, 16: input sample width, signed two's complement
- `DELAY`, 16: correlation lag D in accepted samples, ≥1
- `WIN`, 16: moving-sum window length L in accepted samples, ≥1
- `PROD_SHIFT`, 16: arithmetic right shift applied to each full-width product
- `ACC_W`, 24: accumulator/metric width; must satisfy ACC_W ≥ 2·DATA_W − PROD_SHIFT + clog2(WIN) + 1
- `MIN_RUN`, 8: consecutive above-threshold metric samples required to detect, ≥1
- `HOLDOFF`, 64: metric samples ignored after a detect
- `IDX_W`, 16: width of the metric sample index
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  DATA_W  signed input sample
- `in_valid`  in  1  sample accepted on every cycle it is high; no backpressure
- `thresh`  in  ACC_W  unsigned detection threshold, sampled at each comparison
- `metric`  out  ACC_W  unsigned metric M[n]
- `metric_valid`  out  1  `metric` is valid this cycle
- `detect`  out  1  one-cycle detection pulse
- `peak_idx`  out  IDX_W  index of largest metric in the detected run; held until next detect

## Operation
- Delay line (DELAY deep) of raw samples and window line (WIN deep) of shifted products shift only on a valid sample; contents reset to zero.
- Product p[n] = (x[n]·x[n−D]) >>> PROD_SHIFT, sign-extended to ACC_W.
- Accumulator A[n] = A[n−1] + p[n] − p[n−WIN], signed ACC_W; never overflows given the width rule.
- M[n] = |A[n]|, exact in ACC_W unsigned bits (most-negative value is representable).
- Priming: the first DELAY+WIN−1 accepted samples since reset produce no `metric_valid`. Every accepted sample after that produces exactly one `metric_valid` cycle.
- Metric index counter: 0 at first `metric_valid` after reset, +1 per `metric_valid`, wraps modulo 2^IDX_W.
- Detector FSM, advancing only on `metric_valid` cycles:
  - SEARCH: if M ≥ thresh → RUN, run_cnt=1, peak=M, peak index=current index. If MIN_RUN=1 → detect immediately.
  - RUN: if M ≥ thresh → run_cnt+1; if M > peak, update peak and index (ties keep earliest). When run_cnt reaches MIN_RUN → fire detect, latch `peak_idx`, → HOLD with hold_cnt=HOLDOFF. If M < thresh → SEARCH with no detect.
  - HOLD: hold_cnt−1 per metric sample; on reaching 0 → SEARCH. HOLDOFF=0 returns to SEARCH on the next metric sample.
- `thresh` changes take effect at the next compared sample. The FSM state is unaffected by `in_valid` gaps.

## Timing
- Pipeline: S1 registers input and reads the delay line; S2 registers the product; S3 updates the shift and accumulator; S4 registers abs into `metric`. `metric_valid` follows `in_valid` by exactly 4 cycles, gaps preserved.
- `detect` is high for one cycle, 1 cycle after the `metric_valid` cycle carrying the MIN_RUN-th qualifying sample. `peak_idx` updates in the same cycle as `detect`.
- Reset values: `metric`=0, `metric_valid`=0, `detect`=0, `peak_idx`=0. FSM → SEARCH. All counters, delay/window lines and accumulator cleared. In-flight pipeline samples are discarded.
- Reset mid-run or mid-holdoff: no `detect` is issued. Priming restarts from zero.

## Test plan
- DELAY=4, WIN=4, x=0x4000 constant, continuous valid → no `metric_valid` for first 7 samples. The 8th sample yields `metric_valid` 4 cycles later with metric=16384, steady thereafter; the index starts at 0.
- Same config, pattern of 4×(+0x4000) then 4×(−0x4000) repeating → each product is −4096, A=−16384, metric=16384 (abs path).
- Random samples with random `in_valid` gaps vs same samples gapless → identical `metric` sequences; each `metric_valid` occurs 4 cycles after its input.
- MIN_RUN=3, HOLDOFF=5, thresh=1000, metric sequence 0,1200,1500,1300,900 → `detect` 1 cycle after the 1300 sample; `peak_idx` = index of 1500. Further samples ≥thresh give no detect for the next 5 metric samples.
- Same config, metric 1200,1500,900,1200 → no detect; the FSM returns to SEARCH and the run restarts at the last sample.
- `rst` asserted for 1 cycle while run_cnt=2 → all outputs 0 the next cycle. No detect is issued, and priming repeats (7 samples without `metric_valid` when DELAY=WIN=4).
